tmds_stream_serializer: RTL

TMDS_STREAM_SERIALIZER -- requirements
Module: tmds_stream_serializer

---
 rtl/tmds_stream_serializer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tmds_stream_serializer.sv
// TMDS token serializer: a small token FIFO feeding per-channel LSB-first shift registers.
// Define TMDS_SER_UNDERFLOW_CNT_EN to add a saturating 16-bit underflow_count output.
module tmds_chan_shift #(
  parameter int                 TOKEN_W    = 10,
  parameter int                 LANES      = 2,
  parameter logic [TOKEN_W-1:0] IDLE_TOKEN = 10'b1101010100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               idle_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [TOKEN_W-1:0] token_i,
  output logic [LANES-1:0]   lanes_o
);
  logic [TOKEN_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (idle_i)       sr_d = IDLE_TOKEN;
    else if (load_i)  sr_d = token_i;
    else if (shift_i) sr_d = sr_q >> LANES;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign lanes_o = sr_q[LANES-1:0];
endmodule

module tmds_stream_serializer #(
  parameter int                 NCHAN      = 3,
  parameter int                 TOKEN_W    = 10,
  parameter int                 LANES      = 2,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [TOKEN_W-1:0] IDLE_TOKEN = 10'b1101010100
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NCHAN*TOKEN_W-1:0]          in_token,
  output logic [NCHAN*LANES-1:0]            out_data,
  output logic                              out_load,
  output logic                              underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  ,output logic [15:0]                      underflow_count
`endif
);
  localparam int SLOTS  = TOKEN_W / LANES;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int WORD_W = NCHAN * TOKEN_W;

  logic [FIFO_DEPTH-1:0][WORD_W-1:0] mem_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              start_q, rdy_q, load_q, uf_q;
  logic              push, pop, at_last, do_load, fifo_empty, uf_d;
  logic [WORD_W-1:0] head;

  assign push       = in_valid & rdy_q;
  assign fifo_empty = (level_q == '0);
  // start_q stands in for "slot = SLOTS-1" on the first edge after reset,
  // so an enable held high through reset release still loads immediately.
  assign at_last    = start_q | (slot_q == SLOT_W'(SLOTS-1));
  assign do_load    = en & at_last;
  assign pop        = do_load & ~fifo_empty;
  assign uf_d       = do_load & fifo_empty;
  assign head       = mem_q[rd_ptr_q];
  assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

  always_comb begin
    slot_d = slot_q;
    if (!en)         slot_d = SLOT_W'(SLOTS-1);
    else if (at_last) slot_d = '0;
    else             slot_d = slot_q + SLOT_W'(1);
  end

  // Storage has no reset; only pointers and occupancy define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_token;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      slot_q   <= '0;
      start_q  <= 1'b1;
      rdy_q    <= 1'b0;
      load_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      slot_q  <= slot_d;
      start_q <= 1'b0;
      rdy_q   <= (level_d < LVL_W'(FIFO_DEPTH));
      load_q  <= do_load;
      uf_q    <= uf_d;
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    tmds_chan_shift #(
      .TOKEN_W   (TOKEN_W),
      .LANES     (LANES),
      .IDLE_TOKEN(IDLE_TOKEN)
    ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .idle_i (~en),
      .load_i (do_load),
      .shift_i(en & ~at_last),
      .token_i(fifo_empty ? IDLE_TOKEN : head[c*TOKEN_W +: TOKEN_W]),
      .lanes_o(out_data[c*LANES +: LANES])
    );
  end

  assign in_ready   = rdy_q;
  assign out_load   = load_q;
  assign underflow  = uf_q;
  assign fifo_level = level_q;

`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ucnt_q <= '0;
    else if (uf_d && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end
  assign underflow_count = ucnt_q;
`endif
endmodule
